core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Parametrised multi-cycle control sequencer for the RV32I core. It owns the PC, the instruction register and the stage FSM; datapath decode, ALU and register file stay outside.
- Extends the fixed 6-state IDLE/IF/DE/EX/MA/WB loop with:
  - valid/ack handshakes to instruction and data memory, with arbitrary wait states;
  - optional MA skip for non-memory instructions;
  - a run/stop control;
  - a halt state for ECALL/EBREAK and misaligned targets;
  - a retired-instruction counter.

Parameters:
XLEN, 32, width of PC, imm, rs1_data and the address bus
RESET_PC, 32'h0, PC value loaded at reset
PC_STEP, 4, sequential PC increment
MEM_SKIP, 1, 1 = non-memory instructions go EX->WB directly; 0 = always pass through MA (one idle cycle)
CNT_W, 32, width of retired counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
run  in  1  1 = fetch the next instruction; 0 = park in IDLE after the current WB
imem_req  out  1  instruction fetch request; level, held through IF
imem_addr  out  XLEN  fetch address (= pc)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  fetched instruction
inst  out  32  instruction register, feeds decode
is_mem  in  1  decode: load or store
is_store  in  1  decode: store
is_branch  in  1  decode: conditional branch
branch_taken  in  1  ALU compare result, valid in EX..WB
is_jal  in  1  decode: JAL
is_jalr  in  1  decode: JALR
is_halt  in  1  decode: ECALL/EBREAK
imm  in  XLEN  decoded immediate
rs1_data  in  XLEN  register rs1 value
dmem_req  out  1  data memory request; level, held through MA
dmem_we  out  1  store enable (= is_store while dmem_req)
dmem_ack  in  1  data access complete this cycle
rf_we  out  1  register write enable; 1-cycle pulse in WB
pc  out  XLEN  current PC
state  out  3  IDLE=0 IF=1 DE=2 EX=3 MA=4 WB=5 HALT=6
halted  out  1  1 while in HALT
misaligned  out  1  sticky; set when halt was caused by a misaligned target
retired  out  CNT_W  number of instructions completed through WB

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pc=RESET_PC, inst=0, retired=0, misaligned=0.
  - imem_req, dmem_req, dmem_we, rf_we all 0.
  - Reset mid-handshake abandons the access immediately.
- IDLE: run=1 -> IF next cycle; otherwise stay.
- IF:
  - imem_req=1 and imem_addr=pc for every IF cycle.
  - imem_ack=1 -> inst<=imem_rdata, go to DE.
  - No ack -> stay, with no timeout. run is ignored while in IF.
- DE: 1 cycle -> EX.
- EX: 1 cycle -> MA if (is_mem || MEM_SKIP==0), else WB.
- MA:
  - If is_mem: dmem_req=1, dmem_we=is_store; hold until dmem_ack, then WB.
  - If !is_mem (MEM_SKIP=0 only): no request, 1 cycle -> WB.
- WB (always exactly 1 cycle):
  - rf_we = !(is_store || is_branch || is_halt).
  - next_pc:
    - (is_branch && branch_taken) || is_jal -> pc+imm
    - is_jalr -> (rs1_data+imm) & ~1
    - otherwise -> pc+PC_STEP
    - All sums are mod 2^XLEN; wrap-around is silent.
  - Exit, in priority order:
    1. is_halt: go to HALT; pc unchanged; retired increments.
    2. next_pc[1:0]!=0: go to HALT with misaligned=1; pc unchanged; retired does not increment; rf_we is still asserted (JAL/JALR link write happens).
    3. Otherwise: pc<=next_pc, retired+=1 (saturates at all-ones), then IF if run else IDLE.
- HALT: absorbing. All requests are 0 and halted=1. Only rst exits.
- Outputs are registered except imem_req, imem_addr, dmem_req, dmem_we, rf_we, which are decoded from state.
- Minimum latency with same-cycle acks:
  - non-memory instruction: 4 cycles (IF DE EX WB) with MEM_SKIP=1, 5 with MEM_SKIP=0;
  - load/store: 5 cycles.
  - Each ack wait cycle adds 1.

Test Plan:
- Reset, run=1, imem_ack tied 1, ADDI stream, MEM_SKIP=1 -> IF at cycle 1; pc 0,4,8 at 4-cycle spacing; rf_we once per 4 cycles; retired=3 after 12 cycles.
- Same stream, MEM_SKIP=0 -> 5-cycle spacing; dmem_req never asserted.
- Store, dmem_ack delayed 3 cycles -> dmem_req=1 and dmem_we=1 for 4 cycles; rf_we=0 in WB; pc+=4.
- Taken branch, imm=-8, at pc=0x20 -> pc=0x18. JALR with rs1=0x101, imm=0x4 -> pc=0x104. JAL with imm=0x6 -> misaligned=1, halted=1, pc stays, rf_we pulsed.
- ECALL at pc=0x40 -> HALT, pc=0x40, retired incremented; no further imem_req for 20 cycles. Then rst -> pc=RESET_PC, state=IDLE.
- Assert rst during an IF wait (imem_ack=0) -> outputs reset the same cycle without a clock edge. run=0 during EX -> instruction completes, then IDLE; run=1 -> resumes at next_pc.

Source files
------------

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
//
// Multi-cycle control sequencer for an RV32I core. Owns the program counter,
// the instruction register and the stage FSM. Decode, ALU and register file
// live outside; this block only consumes their decode flags and operands.
//
// Stage loop: IDLE -> IF -> DE -> EX -> [MA] -> WB -> IF/IDLE, plus HALT.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   run               1 = keep fetching; 0 = park in IDLE after the current WB
//   imem_req/addr     instruction fetch request (level through IF) and address
//   imem_ack/rdata    fetch complete this cycle, fetched instruction word
//   inst              instruction register, feeds external decode
//   is_mem .. is_halt decode flags for the instruction held in inst
//   branch_taken      ALU compare result, valid EX..WB
//   imm, rs1_data     immediate and rs1 operand for target calculation
//   dmem_req/we       data access request (level through MA), store enable
//   dmem_ack          data access complete this cycle
//   rf_we             register file write enable, one-cycle pulse in WB
//   pc                current program counter
//   state             FSM state: IDLE=0 IF=1 DE=2 EX=3 MA=4 WB=5 HALT=6
//   halted            1 while in HALT
//   misaligned        sticky, set when HALT was entered on a misaligned target
//   retired           saturating count of instructions completed through WB
//
// Handshake rule (both memory ports): the request is a level that is raised
// on entry to the access state and held, with the address stable, until the
// cycle in which the matching ack is sampled high at the rising clock edge.
// The transfer completes on that edge and the request drops with the state
// change. Any number of wait cycles is allowed; there is no timeout. An ack
// seen outside the access state is ignored. Reset abandons an access at once.
// -----------------------------------------------------------------------------
module core_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4,
    parameter bit              MEM_SKIP = 1'b1,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,

    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst,

    input  logic             is_mem,
    input  logic             is_store,
    input  logic             is_branch,
    input  logic             branch_taken,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic             is_halt,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1_data,

    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,

    output logic             rf_we,
    output logic [XLEN-1:0]  pc,
    output logic [2:0]       state,
    output logic             halted,
    output logic             misaligned,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_DE   = 3'd2,
        S_EX   = 3'd3,
        S_MA   = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [XLEN-1:0]   pc_q;
    logic [31:0]       inst_q;
    logic [CNT_W-1:0]  retired_q;
    logic              misaligned_q;

    // Target calculation, only consumed in WB.
    logic [XLEN-1:0]   pc_rel;
    logic [XLEN-1:0]   jalr_tgt;
    logic [XLEN-1:0]   pc_seq;
    logic [XLEN-1:0]   next_pc;
    logic              next_bad;

    // WB exit decisions.
    logic              wb_retire;
    logic              wb_fault;

    always_comb begin
        pc_rel   = pc_q + imm;
        // JALR clears bit 0 of the target, bit 1 is left for the alignment check.
        jalr_tgt = (rs1_data + imm) & ~XLEN'(1);
        pc_seq   = pc_q + XLEN'(PC_STEP);

        if ((is_branch && branch_taken) || is_jal) begin
            next_pc = pc_rel;
        end else if (is_jalr) begin
            next_pc = jalr_tgt;
        end else begin
            next_pc = pc_seq;
        end

        next_bad = |next_pc[1:0];
    end

    // ECALL/EBREAK retires; a misaligned target does not.
    assign wb_retire = (state_q == S_WB) && (is_halt || !next_bad);
    assign wb_fault  = (state_q == S_WB) && !is_halt && next_bad;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and state-decoded strobes
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_IF;
                end
            end

            S_IF: begin
                // run is deliberately not looked at here: a started fetch
                // always completes.
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_d = S_DE;
                end
            end

            S_DE: begin
                state_d = S_EX;
            end

            S_EX: begin
                if (is_mem || !MEM_SKIP) begin
                    state_d = S_MA;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MA: begin
                // Non-memory instructions only get here with MEM_SKIP=0 and
                // spend exactly one quiet cycle.
                if (is_mem) begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                    if (dmem_ack) begin
                        state_d = S_WB;
                    end
                end else begin
                    state_d = S_WB;
                end
            end

            S_WB: begin
                // The link write of JAL/JALR still happens on a misaligned
                // target; only the PC update is suppressed.
                rf_we = !(is_store || is_branch || is_halt);
                if (is_halt || next_bad) begin
                    state_d = S_HALT;
                end else if (run) begin
                    state_d = S_IF;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // PC, instruction register, fault flag, retired counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            retired_q    <= '0;
            misaligned_q <= 1'b0;
        end else begin
            if ((state_q == S_IF) && imem_ack) begin
                inst_q <= imem_rdata;
            end

            // HALT via ECALL/EBREAK keeps the PC pointing at the instruction.
            if (wb_retire && !is_halt) begin
                pc_q <= next_pc;
            end

            if (wb_retire && (retired_q != {CNT_W{1'b1}})) begin
                retired_q <= retired_q + CNT_W'(1);
            end

            if (wb_fault) begin
                misaligned_q <= 1'b1;
            end
        end
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign state      = state_q;
    assign halted     = (state_q == S_HALT);
    assign misaligned = misaligned_q;
    assign retired    = retired_q;

    // -------------------------------------------------------------------------
    // Structural properties
    // -------------------------------------------------------------------------
    a_halt_quiet : assert property (@(posedge clk) disable iff (rst)
        halted |-> !(imem_req || dmem_req || rf_we));

    a_one_req : assert property (@(posedge clk) disable iff (rst)
        !(imem_req && dmem_req));

    a_we_needs_req : assert property (@(posedge clk) disable iff (rst)
        dmem_we |-> dmem_req);

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

  localparam int XLEN = 32;

  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_BR    = 3;
  localparam int K_JAL   = 4;
  localparam int K_JALR  = 5;
  localparam int K_HALT  = 6;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            run = 1'b0;
  logic            imem_ack = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic            is_mem = 1'b0, is_store = 1'b0, is_branch = 1'b0;
  logic            branch_taken = 1'b0, is_jal = 1'b0, is_jalr = 1'b0, is_halt = 1'b0;
  logic [XLEN-1:0] imm = '0, rs1_data = '0;
  logic            dmem_ack = 1'b0;

  logic            imem_req, dmem_req, dmem_we, rf_we, halted, misaligned;
  logic [XLEN-1:0] imem_addr, pc;
  logic [31:0]     inst, retired;
  logic [2:0]      state;

  core_sequencer #(.XLEN(XLEN), .RESET_PC(32'h0), .PC_STEP(4), .MEM_SKIP(1'b1), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst),
    .is_mem(is_mem), .is_store(is_store), .is_branch(is_branch), .branch_taken(branch_taken),
    .is_jal(is_jal), .is_jalr(is_jalr), .is_halt(is_halt), .imm(imm), .rs1_data(rs1_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc(pc), .state(state), .halted(halted), .misaligned(misaligned),
    .retired(retired)
  );

  // Second instance: MEM_SKIP=0 and a 2-bit counter to reach saturation.
  logic            rst2 = 1'b1;
  logic            run2 = 1'b0;
  logic            imem_req2, dmem_req2, dmem_we2, rf_we2, halted2, misaligned2;
  logic [XLEN-1:0] imem_addr2, pc2;
  logic [31:0]     inst2;
  logic [2:0]      state2;
  logic [1:0]      retired2;

  core_sequencer #(.XLEN(XLEN), .RESET_PC(32'h0), .PC_STEP(4), .MEM_SKIP(1'b0), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst2), .run(run2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(1'b1), .imem_rdata(32'h0000_0013),
    .inst(inst2),
    .is_mem(1'b0), .is_store(1'b0), .is_branch(1'b0), .branch_taken(1'b0),
    .is_jal(1'b0), .is_jalr(1'b0), .is_halt(1'b0), .imm(32'h0), .rs1_data(32'h0),
    .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_ack(1'b0),
    .rf_we(rf_we2), .pc(pc2), .state(state2), .halted(halted2), .misaligned(misaligned2),
    .retired(retired2)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] m_pc  = '0;
  logic [31:0]     m_ret = '0;
  logic            m_mis = 1'b0;
  logic [31:0]     exp_q[$];   // expected instruction words, oldest first

  // ---------------------------------------------------------------- drivers
  task automatic do_reset();
    run = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    m_pc = '0; m_ret = '0; m_mis = 1'b0;
  endtask

  // From IDLE at posedge+1: raise run, spend one IDLE cycle, enter IF.
  task automatic start_run();
    run = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL start_idle: state got %0d expected 0", state);
    end
    @(posedge clk); #1;
  endtask

  // Runs one instruction starting with the DUT in IF at posedge+1.
  task automatic exec_instr(input int kind, input logic [XLEN-1:0] i_imm,
                            input logic [XLEN-1:0] i_rs1, input logic take,
                            input int iw, input int dw, input bit stop);
    int              ph_q[$];
    logic [XLEN-1:0] nxt;
    logic            exp_rf;
    logic [2:0]      exp_st;
    logic [6:0]      exp_v, act_v;
    logic [31:0]     word;
    int              p;

    is_mem = (kind == K_LOAD) || (kind == K_STORE);
    is_store = (kind == K_STORE);
    is_branch = (kind == K_BR);
    branch_taken = take;
    is_jal = (kind == K_JAL);
    is_jalr = (kind == K_JALR);
    is_halt = (kind == K_HALT);
    imm = i_imm;
    rs1_data = i_rs1;

    case (kind)
      K_BR:    nxt = take ? m_pc + i_imm : m_pc + 32'd4;
      K_JAL:   nxt = m_pc + i_imm;
      K_JALR:  nxt = (i_rs1 + i_imm) & 32'hFFFF_FFFE;
      default: nxt = m_pc + 32'd4;
    endcase
    exp_rf = !(kind == K_STORE || kind == K_BR || kind == K_HALT);

    repeat (iw + 1) ph_q.push_back(1);
    ph_q.push_back(2);
    ph_q.push_back(3);
    if (is_mem) repeat (dw + 1) ph_q.push_back(4);
    ph_q.push_back(5);

    word = $urandom;
    exp_q.push_back(word);

    for (int k = 0; k < ph_q.size(); k++) begin
      p = ph_q[k];
      imem_ack = (p == 1) && (k == iw);
      imem_rdata = ((p == 1) && (k == iw)) ? word : $urandom;
      dmem_ack = (p == 4) && (k == ph_q.size() - 2);
      if (stop && p == 3) run = 1'b0;
      @(negedge clk);
      exp_v = {3'(p), p == 1, p == 4, (p == 4) && (kind == K_STORE), (p == 5) && exp_rf};
      act_v = {state, imem_req, dmem_req, dmem_we, rf_we};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL strobes: {state,ireq,dreq,we,rfwe} got %b expected %b (kind %0d step %0d)",
                 act_v, exp_v, kind, k);
      end
      if (p == 1) begin
        checks++;
        if (imem_addr !== m_pc) begin
          errors++;
          $display("FAIL imem_addr: got %h expected %h", imem_addr, m_pc);
        end
      end
      if (p == 2) begin
        checks++;
        if (inst !== exp_q[0]) begin
          errors++;
          $display("FAIL inst: got %h expected %h", inst, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;

    if (kind == K_HALT) begin
      m_ret = m_ret + 1;
      exp_st = 3'd6;
    end else if (nxt[1:0] != 2'b00) begin
      m_mis = 1'b1;
      exp_st = 3'd6;
    end else begin
      m_pc = nxt;
      m_ret = m_ret + 1;
      exp_st = run ? 3'd1 : 3'd0;
    end

    checks++;
    if ({pc, retired, misaligned, halted, state} !== {m_pc, m_ret, m_mis, exp_st == 3'd6, exp_st}) begin
      errors++;
      $display("FAIL after_wb: pc %h ret %0d mis %b halted %b state %0d expected pc %h ret %0d mis %b state %0d",
               pc, retired, misaligned, halted, state, m_pc, m_ret, m_mis, exp_st);
    end
    is_mem = 0; is_store = 0; is_branch = 0; branch_taken = 0;
    is_jal = 0; is_jalr = 0; is_halt = 0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    #3;
    checks++;
    if ({state, pc, inst, retired, misaligned, imem_req, dmem_req, dmem_we, rf_we, halted} !==
        {3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: state %0d pc %h inst %h ret %0d mis %b req %b%b we %b rf %b",
               state, pc, inst, retired, misaligned, imem_req, dmem_req, dmem_we, rf_we);
    end
    do_reset();
  endtask

  // ADDI stream with same-cycle acks: 4 cycles per instruction.
  task automatic test_addi_stream();
    int n, p;
    logic [2:0] st_tab [4];
    st_tab = '{3'd1, 3'd2, 3'd3, 3'd5};
    run = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_0013;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      n = (c - 1) / 4;
      p = (c - 1) % 4;
      checks++;
      if (c == 0) begin
        if (state !== 3'd0) begin
          errors++;
          $display("FAIL stream_idle: state got %0d expected 0", state);
        end
      end else if ({state, pc, rf_we, retired} !== {st_tab[p], 32'(4 * n), p == 3, 32'(n)}) begin
        errors++;
        $display("FAIL stream c%0d: state %0d pc %h rf %b ret %0d expected state %0d pc %h ret %0d",
                 c, state, pc, rf_we, retired, st_tab[p], 4 * n, n);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({retired, pc} !== {32'd3, 32'd12}) begin
      errors++;
      $display("FAIL stream_retired: ret %0d pc %h expected 3 and 0000000c", retired, pc);
    end
    m_pc = 32'd12;
    m_ret = 32'd3;
  endtask

  task automatic test_random();
    int kind, off;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      off = ($urandom_range(0, 64) - 32) * 4;
      exec_instr(kind, 32'(off), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_store();
    logic [XLEN-1:0] pc0;
    pc0 = m_pc;
    exec_instr(K_STORE, 32'h0, 32'h0, 1'b0, 1, 3, 1'b0);
    checks++;
    if (pc !== pc0 + 32'd4) begin
      errors++;
      $display("FAIL store_pc: got %h expected %h", pc, pc0 + 32'd4);
    end
  endtask

  task automatic test_branch_jalr();
    exec_instr(K_JAL, 32'h20 - m_pc, 32'h0, 1'b0, 0, 0, 1'b0);
    exec_instr(K_BR, 32'hFFFF_FFF8, 32'h0, 1'b1, 2, 0, 1'b0);
    checks++;
    if (pc !== 32'h18) begin
      errors++;
      $display("FAIL branch_target: got %h expected 00000018", pc);
    end
    exec_instr(K_JALR, 32'h4, 32'h101, 1'b0, 0, 0, 1'b0);
    checks++;
    if (pc !== 32'h104) begin
      errors++;
      $display("FAIL jalr_target: got %h expected 00000104", pc);
    end
  endtask

  task automatic test_run_stop();
    exec_instr(K_ALU, 32'h0, 32'h0, 1'b0, 0, 0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({state, imem_req} !== {3'd0, 1'b0}) begin
        errors++;
        $display("FAIL parked: state %0d ireq %b expected 0 0", state, imem_req);
      end
      @(posedge clk); #1;
    end
    start_run();
    exec_instr(K_LOAD, 32'h0, 32'h0, 1'b0, 1, 2, 1'b0);
  endtask

  task automatic test_misaligned();
    logic [XLEN-1:0] pc0;
    logic [31:0]     r0;
    pc0 = m_pc;
    r0 = m_ret;
    exec_instr(K_JAL, 32'h6, 32'h0, 1'b0, 0, 0, 1'b0);
    checks++;
    if ({pc, retired, misaligned, halted} !== {pc0, r0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL misaligned: pc %h ret %0d mis %b halted %b expected %h %0d 1 1",
               pc, retired, misaligned, halted, pc0, r0);
    end
    do_reset();
  endtask

  task automatic test_halt();
    start_run();
    exec_instr(K_JAL, 32'h40, 32'h0, 1'b0, 0, 0, 1'b0);
    exec_instr(K_HALT, 32'h0, 32'h0, 1'b0, 1, 0, 1'b0);
    checks++;
    if ({pc, retired} !== {32'h40, 32'd2}) begin
      errors++;
      $display("FAIL ecall: pc %h ret %0d expected 00000040 2", pc, retired);
    end
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({imem_req, dmem_req, rf_we, halted, state} !== {1'b0, 1'b0, 1'b0, 1'b1, 3'd6}) begin
        errors++;
        $display("FAIL halt_hold c%0d: ireq %b dreq %b rf %b halted %b state %0d",
                 c, imem_req, dmem_req, rf_we, halted, state);
      end
      @(posedge clk); #1;
    end
    do_reset();
    checks++;
    if ({pc, state, halted} !== {32'h0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL halt_reset: pc %h state %0d halted %b expected 0 0 0", pc, state, halted);
    end
  endtask

  task automatic test_reset_mid_if();
    start_run();
    exec_instr(K_ALU, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0);
    imem_ack = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({state, imem_req, pc, retired, inst} !== {3'd0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid_if: state %0d ireq %b pc %h ret %0d inst %h",
               state, imem_req, pc, retired, inst);
    end
    exp_q.delete();
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    m_pc = '0; m_ret = '0; m_mis = 1'b0;
  endtask

  // MEM_SKIP=0: 5 cycles per non-memory instruction, no data requests,
  // 2-bit counter saturating at 3.
  task automatic test_mem_skip0();
    int n, p;
    logic [2:0] st_tab [5];
    logic [1:0] exp_r;
    st_tab = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    rst2 = 1'b0;
    run2 = 1'b1;
    for (int c = 0; c <= 26; c++) begin
      @(negedge clk);
      n = (c - 1) / 5;
      p = (c - 1) % 5;
      exp_r = (n > 3) ? 2'd3 : 2'(n);
      checks++;
      if (c == 0) begin
        if (state2 !== 3'd0) begin
          errors++;
          $display("FAIL skip0_idle: state got %0d expected 0", state2);
        end
      end else if ({state2, pc2, rf_we2, dmem_req2, retired2} !==
                   {st_tab[p], 32'(4 * n), p == 4, 1'b0, exp_r}) begin
        errors++;
        $display("FAIL skip0 c%0d: state %0d pc %h rf %b dreq %b ret %0d expected state %0d pc %h ret %0d",
                 c, state2, pc2, rf_we2, dmem_req2, retired2, st_tab[p], 4 * n, exp_r);
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_addi_stream();
    test_random();
    test_store();
    test_branch_jalr();
    test_run_stop();
    test_misaligned();
    test_halt();
    test_reset_mid_if();
    test_mem_skip0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
